psum_sum_xchg: RTL and testbench
================================

# psum_sum_xchg

Per-row sum engine between the psum memory and the normaliser. It captures one psum row of `col` lanes and streams the lanes one per cycle to `norm`. While streaming it builds the local row sum, then trades that sum with `npeer` peer cores over 4-phase req/ack handshakes and outputs the global sum. It replaces the fixed 8-lane select counter and single-peer exchange with a parametrised lane count, N-peer exchange, and a selectable signed/absolute sum mode.

## Interface
- `bw_psum`, 20: width of one psum lane, two's complement.
- `col`, 8: lanes per row, ≥2.
- `npeer`, 1: number of peer cores, ≥1.
- `sum_bw`, `bw_psum+4`: local sum width. Must be ≥ `bw_psum+$clog2(col)+1`.
- `gsum_bw` (localparam), `sum_bw+$clog2(npeer+1)`: global sum width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle pulse; captures `row_in` and `mode`.
- `row_in` in `bw_psum*col`: lane k is bits [(k+1)*bw_psum-1 : k*bw_psum].
- `mode` in 1: 0 = signed sum, 1 = sum of absolute values.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `lane_out` out `bw_psum`: serialised lane data.
- `lane_valid` out 1: `lane_out` holds a valid lane.
- `lane_idx` out `$clog2(col)`: index of the lane on `lane_out`.
- `local_sum` out `sum_bw`: this core's row sum; driven on `tx_data`.
- `tx_req` out 1: 4-phase request to all peers.
- `tx_ack` in `npeer`: per-peer acknowledge.
- `rx_req` in `npeer`: per-peer incoming request.
- `rx_data` in `npeer*sum_bw`: per-peer sum; stable while the matching `rx_req` is high.
- `rx_ack` out `npeer`: per-peer acknowledge.
- `global_sum` out `gsum_bw`: local sum plus all peer sums.
- `sum_valid` out 1: one-cycle pulse when `global_sum` is updated.

## Operation
- FSM states: IDLE, SCAN, XCHG, RELEASE, DONE.
- IDLE
  - `start` latches `row_in` and `mode`, clears `local_sum` and the rx-got flags, then moves to SCAN.
- SCAN
  - Lane counter runs 0..col-1, one lane per cycle.
  - Each lane is sign-extended to `sum_bw`. In mode 1 it is negated if negative.
  - The result is added to `local_sum`.
  - Arithmetic wraps and never saturates. The width rule guarantees no overflow.
  - After lane col-1, moves to XCHG.
- XCHG
  - `tx_req`=1.
  - Per-peer sticky flag sets when the synchronised `tx_ack[i]` is seen high.
  - When all flags are set, `tx_req`=0 and the FSM moves to RELEASE.
- RELEASE
  - Waits for all synchronised `tx_ack` to be low and all rx-got flags to be set.
  - Then moves to DONE.
- DONE
  - `global_sum` = sign-extended `local_sum` + Σ sign-extended captured rx sums.
  - `sum_valid`=1 for this cycle, then back to IDLE.
- Receive side
  - Runs independently per peer, in any state, including before this core reaches XCHG.
  - Synchronised `rx_req[i]` rising with got[i]=0: capture `rx_data[i]`, set got[i], raise `rx_ack[i]`.
  - `rx_ack[i]` drops when the synchronised `rx_req[i]` falls.
  - A second request while got[i]=1 is held unacknowledged until got is cleared by the next `start`.
- `start` while `busy` is ignored.
- `local_sum` and `global_sum` hold until the next accepted `start`.

## Timing
- Reset: every output is 0, FSM goes to IDLE, flags and synchronisers are cleared. This applies at any point, including mid-SCAN or mid-handshake. Peers must tolerate a request or ack dropping early.
- `start` sampled at edge T:
  - `lane_valid`=1 in cycles T+1..T+col, with `lane_idx`=0..col-1.
  - `local_sum` is final at T+col+1.
  - `tx_req` rises at T+col+1.
- `tx_ack` and `rx_req` each pass through a 2-flop synchroniser (2-cycle input latency). `rx_data` is sampled at the synchronised edge.
- Minimum `start`-to-`sum_valid` with peers that respond immediately: col+7 cycles.
- `rx_ack` rises 3 cycles after the raw `rx_req` rises, and falls 3 cycles after the raw `rx_req` falls.
- Simultaneous events in the same cycle are all honoured: rx capture, tx_ack set, and a state change.

## Structure
- Package `psum_xchg_pkg` holds:
  - the FSM state enum;
  - the `sum_bw` and `gsum_bw` width-rule functions;
  - a `SYNC_STAGES`=2 constant.
- Sub-module `xchg_rx_port` contains one peer's receive path: synchroniser, got flag, data latch and `rx_ack`. It is instantiated `npeer` times via generate.
- The top level holds the FSM, lane counter, accumulator, tx flags and the global adder.

## Test plan
- **Signed sum, one peer.** col=8, npeer=1, mode 0, lanes 1..8, peer sends 100.
  - `lane_out` runs 1..8 over 8 cycles.
  - `local_sum`=36, `global_sum`=136, a single `sum_valid` pulse.
- **Absolute mode.** Lanes -1..-8.
  - Mode 1: `local_sum`=36.
  - Mode 0: `local_sum`=-36 (two's complement). Lane -2^19 in mode 1 gives +2^19 with no wrap.
- **Three peers, staggered.** npeer=3, sending 10, 20, 30. Acks arrive at +1, +5 and +12 cycles.
  - `tx_req` stays high until the last ack; `global_sum`=local+60.
- **Early receive.** Peer `rx_req` arrives during SCAN.
  - Captured during SCAN, `rx_ack` at +3 cycles, no loss, correct `global_sum`.
- **Ignored start.** `start` pulsed mid-SCAN.
  - No restart; lane sequence and sum are unchanged.
- **Async reset.** `reset` asserted during XCHG.
  - All outputs are 0 with no clock edge. Next `start` completes normally.

Source files
------------

// File: rtl/psum_xchg_pkg.sv
// rtl/psum_xchg_pkg.sv - shared states, width rules and constants for the psum sum exchange
package psum_xchg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_XCHG,
        ST_RELEASE,
        ST_DONE
    } xchg_state_e;

    localparam int SYNC_STAGES = 2;

    // Smallest local sum width that cannot overflow for col lanes, even in absolute mode.
    function automatic int min_sum_bw(input int bw_psum, input int col);
        return bw_psum + $clog2(col) + 1;
    endfunction

    function automatic int calc_gsum_bw(input int sum_bw, input int npeer);
        return sum_bw + $clog2(npeer + 1);
    endfunction

endpackage

// File: rtl/xchg_rx_port.sv
// rtl/xchg_rx_port.sv - one peer's receive path: request synchroniser, got flag, data latch, ack
module xchg_rx_port
    import psum_xchg_pkg::*;
#(
    parameter int sum_bw = 24
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_rx_req,
    input  logic [sum_bw-1:0] i_rx_data,
    output logic              o_rx_ack,
    output logic              o_got,
    output logic [sum_bw-1:0] o_data
);

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_got;
    logic                   r_ack;
    logic [sum_bw-1:0]      r_data;
    logic                   w_req;
    logic                   w_take;

    assign w_req = r_req_sync[SYNC_STAGES-1];
    // A request still high from the previous row (ack up) must not be taken twice after a clear.
    assign w_take = w_req && !r_ack && (!r_got || i_clr);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req_sync <= '0;
            r_got      <= 1'b0;
            r_ack      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_rx_req};
            if (w_take) begin
                r_data <= i_rx_data;
                r_got  <= 1'b1;
            end else if (i_clr) begin
                r_got <= 1'b0;
            end
            if (w_take) begin
                r_ack <= 1'b1;
            end else if (!w_req) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign o_rx_ack = r_ack;
    assign o_got    = r_got;
    assign o_data   = r_data;

endmodule

// File: rtl/psum_sum_xchg.sv
// rtl/psum_sum_xchg.sv - streams a psum row lane by lane, sums it and exchanges sums with peers
module psum_sum_xchg
    import psum_xchg_pkg::*;
#(
    parameter  int bw_psum = 20,
    parameter  int col     = 8,
    parameter  int npeer   = 1,
    parameter  int sum_bw  = bw_psum + 4,
    localparam int gsum_bw = calc_gsum_bw(sum_bw, npeer),
    localparam int lw      = $clog2(col)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [bw_psum*col-1:0]  row_in,
    input  logic                    mode,
    output logic                    busy,
    output logic [bw_psum-1:0]      lane_out,
    output logic                    lane_valid,
    output logic [lw-1:0]           lane_idx,
    output logic [sum_bw-1:0]       local_sum,
    output logic                    tx_req,
    input  logic [npeer-1:0]        tx_ack,
    input  logic [npeer-1:0]        rx_req,
    input  logic [npeer*sum_bw-1:0] rx_data,
    output logic [npeer-1:0]        rx_ack,
    output logic [gsum_bw-1:0]      global_sum,
    output logic                    sum_valid
);

    xchg_state_e         r_state;
    xchg_state_e         w_state_nxt;
    logic [bw_psum*col-1:0] r_row;
    logic                r_mode;
    logic [lw-1:0]       r_lane;
    logic [sum_bw-1:0]   r_local_sum;
    logic [gsum_bw-1:0]  r_global_sum;
    logic [npeer-1:0]    r_tx_got;
    logic [npeer-1:0]    r_ack_sync [SYNC_STAGES];
    logic [npeer-1:0]    w_rx_got;
    logic [sum_bw-1:0]   w_rx_sum [npeer];
    logic [bw_psum-1:0]  w_lane;
    logic [sum_bw-1:0]   w_lane_ext;
    logic [sum_bw-1:0]   w_term;
    logic [gsum_bw-1:0]  w_global_sum;
    logic                w_start_ok;
    logic                w_tx_all;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_tx_all   = &r_tx_got;
    assign w_lane     = r_row[r_lane*bw_psum +: bw_psum];
    assign w_lane_ext = {{(sum_bw-bw_psum){w_lane[bw_psum-1]}}, w_lane};
    assign w_term     = (r_mode && w_lane[bw_psum-1]) ? -w_lane_ext : w_lane_ext;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        lane_valid  = 1'b0;
        tx_req      = 1'b0;
        sum_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                busy       = 1'b1;
                lane_valid = 1'b1;
                if (r_lane == lw'(col - 1)) w_state_nxt = ST_XCHG;
            end
            ST_XCHG: begin
                busy   = 1'b1;
                tx_req = !w_tx_all;
                if (w_tx_all) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                busy = 1'b1;
                if (!(|r_ack_sync[SYNC_STAGES-1]) && (&w_rx_got)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy        = 1'b1;
                sum_valid   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_global_sum = {{(gsum_bw-sum_bw){r_local_sum[sum_bw-1]}}, r_local_sum};
        for (int i = 0; i < npeer; i++) begin
            w_global_sum = w_global_sum + {{(gsum_bw-sum_bw){w_rx_sum[i][sum_bw-1]}}, w_rx_sum[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_row        <= '0;
            r_mode       <= 1'b0;
            r_lane       <= '0;
            r_local_sum  <= '0;
            r_global_sum <= '0;
            r_tx_got     <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) r_ack_sync[s] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ack_sync[0] <= tx_ack;
            for (int s = 1; s < SYNC_STAGES; s++) r_ack_sync[s] <= r_ack_sync[s-1];
            if (w_start_ok) begin
                r_row       <= row_in;
                r_mode      <= mode;
                r_lane      <= '0;
                r_local_sum <= '0;
                r_tx_got    <= '0;
            end
            if (r_state == ST_SCAN) begin
                r_local_sum <= r_local_sum + w_term;
                r_lane      <= r_lane + lw'(1);
            end
            if (r_state == ST_XCHG) r_tx_got <= r_tx_got | r_ack_sync[SYNC_STAGES-1];
            if (w_state_nxt == ST_DONE) r_global_sum <= w_global_sum;
        end
    end

    // Receive ports run in every state so early peers are never lost.
    for (genvar i = 0; i < npeer; i++) begin : g_rx
        xchg_rx_port #(
            .sum_bw(sum_bw)
        ) u_rx (
            .clk      (clk),
            .i_rst_n  (reset),
            .i_clr    (w_start_ok),
            .i_rx_req (rx_req[i]),
            .i_rx_data(rx_data[i*sum_bw +: sum_bw]),
            .o_rx_ack (rx_ack[i]),
            .o_got    (w_rx_got[i]),
            .o_data   (w_rx_sum[i])
        );
    end

    assign lane_out   = lane_valid ? w_lane : '0;
    assign lane_idx   = lane_valid ? r_lane : '0;
    assign local_sum  = r_local_sum;
    assign global_sum = r_global_sum;

endmodule

// File: tb/tb_psum_sum_xchg.sv
// tb/tb_psum_sum_xchg.sv - randomized and directed checks of psum_sum_xchg against a behavioural model
module tb_psum_sum_xchg;

    localparam int BW  = 20;
    localparam int COL = 8;
    localparam int NP  = 3;
    localparam int SBW = BW + 4;
    localparam int GBW = SBW + $clog2(NP + 1);
    localparam int LW  = $clog2(COL);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [BW*COL-1:0] row_in = '0;
    logic              mode = 1'b0;
    logic              busy;
    logic [BW-1:0]     lane_out;
    logic              lane_valid;
    logic [LW-1:0]     lane_idx;
    logic [SBW-1:0]    local_sum;
    logic              tx_req;
    logic [NP-1:0]     tx_ack = '0;
    logic [NP-1:0]     rx_req = '0;
    logic [NP*SBW-1:0] rx_data = '0;
    logic [NP-1:0]     rx_ack;
    logic [GBW-1:0]    global_sum;
    logic              sum_valid;

    psum_sum_xchg #(.bw_psum(BW), .col(COL), .npeer(NP), .sum_bw(SBW)) dut (
        .clk(clk), .reset(reset), .start(start), .row_in(row_in), .mode(mode),
        .busy(busy), .lane_out(lane_out), .lane_valid(lane_valid), .lane_idx(lane_idx),
        .local_sum(local_sum), .tx_req(tx_req), .tx_ack(tx_ack), .rx_req(rx_req),
        .rx_data(rx_data), .rx_ack(rx_ack), .global_sum(global_sum), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int lanes [COL];
    int tx_dly [NP];
    int rx_off [NP];
    logic [SBW-1:0] rx_val [NP];
    int tx_cnt [NP];
    int tx_up_n [NP];
    int rx_st [NP];
    int rx_rise [NP];
    int rx_fall [NP];
    int n;
    int sv_n;
    int glitch_at;
    logic cur_mode;
    logic [SBW-1:0] cap_local;
    logic [GBW-1:0] cap_global;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    function automatic longint model_local_full(input logic m);
        longint s;
        longint v;
        s = 0;
        for (int k = 0; k < COL; k++) begin
            v = lanes[k];
            if (m && v < 0) v = -v;
            s += v;
        end
        return s;
    endfunction

    function automatic logic [SBW-1:0] model_local(input logic m);
        longint s;
        s = model_local_full(m);
        return s[SBW-1:0];
    endfunction

    function automatic logic [GBW-1:0] model_global(input logic m);
        longint s;
        longint t;
        s = model_local_full(m);
        for (int i = 0; i < NP; i++) begin
            t = {{(64-SBW){rx_val[i][SBW-1]}}, rx_val[i]};
            s += t;
        end
        return s[GBW-1:0];
    endfunction

    // Peer-visible event times give the exact completion cycle: two sync stages on each side.
    function automatic int last_tx_raise();
        int m;
        m = -1;
        for (int i = 0; i < NP; i++) begin
            if (tx_up_n[i] < 0) return -1;
            if (tx_up_n[i] > m) m = tx_up_n[i];
        end
        return m;
    endfunction

    function automatic int calc_done();
        int a;
        int d;
        a = last_tx_raise();
        if (a < 0) return 1 << 30;
        d = a + 5;
        for (int i = 0; i < NP; i++) begin
            if (rx_rise[i] < 0) return 1 << 30;
            if (rx_rise[i] + 3 > d) d = rx_rise[i] + 3;
        end
        return d + 1;
    endfunction

    function automatic logic exp_tx_req();
        int a;
        a = last_tx_raise();
        return (n >= COL + 1) && (a < 0 || n < a + 3);
    endfunction

    task automatic drive_peers();
        for (int i = 0; i < NP; i++) begin
            if (tx_req && !tx_ack[i]) begin
                if (tx_cnt[i] >= tx_dly[i]) begin
                    tx_ack[i]  = 1'b1;
                    tx_up_n[i] = n;
                end else begin
                    tx_cnt[i]++;
                end
            end else if (!tx_req && tx_ack[i]) begin
                tx_ack[i] = 1'b0;
            end
            case (rx_st[i])
                0: if (n >= rx_off[i]) begin
                    rx_data[i*SBW +: SBW] = rx_val[i];
                    rx_req[i]  = 1'b1;
                    rx_rise[i] = n;
                    rx_st[i]   = 1;
                end
                1: if (rx_ack[i]) begin
                    rx_req[i]  = 1'b0;
                    rx_fall[i] = n;
                    rx_st[i]   = 2;
                end
                2: if (!rx_ack[i]) rx_st[i] = 3;
                default: ;
            endcase
        end
    endtask

    task automatic step();
        int ed;
        logic e;
        logic [BW-1:0] exp_lane;
        @(negedge clk);
        n++;
        ed = calc_done();
        chk("busy", busy, (n >= 1 && n <= ed));
        chk("lane_valid", lane_valid, (n >= 1 && n <= COL));
        if (n >= 1 && n <= COL) begin
            exp_lane = lanes[n-1][BW-1:0];
            chk("lane_idx", lane_idx, n - 1);
            chk("lane_out", lane_out, exp_lane);
        end
        chk("tx_req", tx_req, exp_tx_req());
        chk("sum_valid", sum_valid, n == ed);
        if (sum_valid && sv_n < 0) sv_n = n;
        if (n == COL + 1) chk("local_sum", local_sum, model_local(cur_mode));
        if (n == ed || n == ed + 1) begin
            chk("global_sum", global_sum, model_global(cur_mode));
            chk("local_hold", local_sum, model_local(cur_mode));
        end
        if (n == ed) begin
            cap_local  = local_sum;
            cap_global = global_sum;
        end
        for (int i = 0; i < NP; i++) begin
            case (rx_st[i])
                1: e = (n - rx_rise[i] >= 3);
                2: e = (n - rx_fall[i] < 3);
                default: e = 1'b0;
            endcase
            chk("rx_ack", rx_ack[i], e);
        end
        drive_peers();
        start = (n == glitch_at);
    endtask

    task automatic run_xact(input logic m, input int glitch, input int abort_at);
        logic all_done;
        for (int k = 0; k < COL; k++) row_in[k*BW +: BW] = lanes[k][BW-1:0];
        for (int i = 0; i < NP; i++) begin
            tx_cnt[i]  = 0;
            tx_up_n[i] = -1;
            rx_st[i]   = 0;
            rx_rise[i] = -1;
            rx_fall[i] = -1;
        end
        mode      = m;
        cur_mode  = m;
        glitch_at = glitch;
        sv_n      = -1;
        n         = 0;
        start     = 1'b1;
        drive_peers();
        forever begin
            step();
            if (n == abort_at) return;
            all_done = 1'b1;
            for (int i = 0; i < NP; i++) if (rx_st[i] != 3) all_done = 1'b0;
            if (all_done && n > calc_done()) break;
            if (n > 400) begin
                tests++;
                fails++;
                $display("FAIL timeout: transaction not complete after %0d cycles, required done by 400", n);
                break;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_lane_valid"}, lane_valid, 0);
        chk({tag, "_lane_out"}, lane_out, 0);
        chk({tag, "_lane_idx"}, lane_idx, 0);
        chk({tag, "_local_sum"}, local_sum, 0);
        chk({tag, "_tx_req"}, tx_req, 0);
        chk({tag, "_rx_ack"}, rx_ack, 0);
        chk({tag, "_global_sum"}, global_sum, 0);
        chk({tag, "_sum_valid"}, sum_valid, 0);
    endtask

    task automatic rand_setup();
        for (int k = 0; k < COL; k++) lanes[k] = int'($urandom_range(0, 1048575)) - 524288;
        for (int i = 0; i < NP; i++) begin
            rx_val[i] = SBW'($urandom);
            tx_dly[i] = int'($urandom_range(0, 12));
            rx_off[i] = int'($urandom_range(0, 20));
        end
    endtask

    initial begin
        n = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Signed sum, staggered acks, early receives during the scan.
        for (int k = 0; k < COL; k++) lanes[k] = k + 1;
        rx_val = '{24'd10, 24'd20, 24'd30};
        tx_dly = '{1, 5, 12};
        rx_off = '{2, 4, 6};
        run_xact(1'b0, -1, -1);
        chk("pin_local_signed", cap_local, 36);
        chk("pin_global_3peer", cap_global, 96);

        for (int k = 0; k < COL; k++) lanes[k] = -(k + 1);
        rx_val = '{24'd100, 24'd0, 24'd0};
        run_xact(1'b1, -1, -1);
        chk("pin_local_abs", cap_local, 36);
        chk("pin_global_abs", cap_global, 136);

        rx_val = '{24'd10, 24'd20, 24'd30};
        run_xact(1'b0, -1, -1);
        chk("pin_local_neg", cap_local, 24'hFFFFDC);
        chk("pin_global_neg", cap_global, 24);

        for (int k = 0; k < COL; k++) lanes[k] = 0;
        lanes[0] = -524288;
        run_xact(1'b1, -1, -1);
        chk("pin_abs_min", cap_local, 524288);

        // Immediate peers give the minimum start-to-sum_valid latency.
        rand_setup();
        tx_dly = '{0, 0, 0};
        rx_off = '{0, 0, 0};
        run_xact(1'b0, -1, -1);
        chk("pin_min_latency", sv_n, COL + 7);

        rand_setup();
        run_xact(1'b1, 3, -1);

        // Asynchronous reset in the middle of the exchange.
        rand_setup();
        tx_dly = '{10, 10, 10};
        rx_off = '{0, COL + 2, 40};
        run_xact(1'b0, -1, COL + 3);
        #2 reset = 1'b0;
        #1 chk_zero("async_rst");
        start   = 1'b0;
        tx_ack  = '0;
        rx_req  = '0;
        rx_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rand_setup();
        run_xact(1'b1, -1, -1);

        for (int t = 0; t < 25; t++) begin
            rand_setup();
            run_xact(1'($urandom_range(0, 1)), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
